// File: rtl/memory.sv
`default_nettype none
//==============================================================================
// Module   : memory
// Purpose  : Small register-file memory of CELL_COUNT 8-bit cells with one
//            synchronous write port and one combinational (zero-latency) read
//            port. Out-of-range writes are dropped and out-of-range reads
//            return 8'h00. An asynchronous reset clears every cell.
//
// Parameters
//   CELL_COUNT    : number of 8-bit cells, legal range 1..256 (default 4)
//
// Ports
//   clock         : in  1  rising-edge clock
//   reset         : in  1  asynchronous active-high reset, clears all cells
//   read_address  : in  8  cell index for the read port
//   write_address : in  8  cell index for the write port
//   write_data    : in  8  data stored on a write
//   write_enable  : in  1  write strobe, sampled on rising clock
//   read_data     : out 8  contents of cell[read_address], or 8'h00
//
// Build option
//   MEMORY_WRITE_BYPASS_EN : when defined, a same-address read during an
//                            enabled in-range write returns write_data
//                            combinationally (write-through).
//
// Revision : 1.0  initial release
//==============================================================================
module memory #(
   parameter int CELL_COUNT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] read_address,
   input  logic [7:0] write_address,
   input  logic [7:0] write_data,
   input  logic       write_enable,
   output logic [7:0] read_data
);

   // Storage: one 8-bit register per cell.
   logic [7:0] r_cells [CELL_COUNT];

   // Combinational read result before the optional bypass override.
   logic [7:0] w_stored_data;

   //---------------------------------------------------------------------------
   // Write port. Each cell compares its own index against write_address, so an
   // address at or above CELL_COUNT matches no cell and the write is dropped
   // without any wrap-around. At most one cell can match per edge.
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CELL_COUNT; i++) begin
            r_cells[i] <= 8'h00;
         end
      end else if (write_enable) begin
         for (int i = 0; i < CELL_COUNT; i++) begin
            if (write_address == 8'(i)) begin
               r_cells[i] <= write_data;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Read port. Default of 8'h00 covers out-of-range addresses.
   //---------------------------------------------------------------------------
   always_comb begin
      w_stored_data = 8'h00;
      for (int i = 0; i < CELL_COUNT; i++) begin
         if (read_address == 8'(i)) begin
            w_stored_data = r_cells[i];
         end
      end
   end

`ifdef MEMORY_WRITE_BYPASS_EN
   // Write-through: forward write_data when the read hits the cell being
   // written this cycle. The range check keeps out-of-range writes from
   // leaking onto an out-of-range read (which must stay 8'h00).
   logic w_write_in_range;

   always_comb begin
      w_write_in_range = 1'b0;
      for (int i = 0; i < CELL_COUNT; i++) begin
         if (write_address == 8'(i)) begin
            w_write_in_range = 1'b1;
         end
      end
   end

   always_comb begin
      read_data = w_stored_data;
      if (write_enable && !reset && w_write_in_range &&
          (read_address == write_address)) begin
         read_data = write_data;
      end
   end
`else
   assign read_data = w_stored_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
//==============================================================================
// Module   : tb_memory
// Purpose  : Self-checking bench for memory (CELL_COUNT = 4). Directed vector
//            table plus hand-written sequences for reset, sweep and
//            same-address read/write behaviour.
// Revision : 1.0  initial release
//==============================================================================
module tb_memory;

   localparam int CELL_COUNT = 4;

   logic       clock;
   logic       reset;
   logic [7:0] read_address;
   logic [7:0] write_address;
   logic [7:0] write_data;
   logic       write_enable;
   logic [7:0] read_data;

   int checks;
   int failures;

   memory #(
      .CELL_COUNT(CELL_COUNT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .read_address (read_address),
      .write_address(write_address),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_data    (read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic       we;
      logic [7:0] waddr;
      logic [7:0] wdata;
      logic [7:0] raddr;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [12];
   logic [7:0] model [CELL_COUNT];

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic we,
                               input logic [7:0] waddr, input logic [7:0] wdata,
                               input logic [7:0] raddr, input logic [7:0] exp);
      vec_t v;
      v.name  = name;
      v.we    = we;
      v.waddr = waddr;
      v.wdata = wdata;
      v.raddr = raddr;
      v.exp   = exp;
      return v;
   endfunction

   // Read all in-range cells combinationally and compare with the model.
   task automatic sweep(input string name);
      for (int a = 0; a < CELL_COUNT; a++) begin
         read_address = 8'(a);
         #1;
         check(name, read_data, model[a]);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      read_address  = 8'h00;
      write_address = 8'h00;
      write_data    = 8'h00;
      write_enable  = 1'b0;

      // Reset pulse, then every cell reads 00.
      #2 reset = 1'b1;
      #6 reset = 1'b0;
      for (int a = 0; a < CELL_COUNT; a++) model[a] = 8'h00;
      @(negedge clock);
      sweep("reset_state");

      // Directed vectors: inputs applied at negedge, read checked after edge.
      vecs[0]  = mk("wr0",          1'b1, 8'd0,   8'h11, 8'd0,   8'h11);
      vecs[1]  = mk("wr1",          1'b1, 8'd1,   8'h22, 8'd1,   8'h22);
      vecs[2]  = mk("wr2_rd0",      1'b1, 8'd2,   8'h33, 8'd0,   8'h11);
      vecs[3]  = mk("wr3",          1'b1, 8'd3,   8'h44, 8'd3,   8'h44);
      vecs[4]  = mk("we0_hold1",    1'b0, 8'd1,   8'hAA, 8'd1,   8'h22);
      vecs[5]  = mk("oor_wr_rd4",   1'b1, 8'd4,   8'h55, 8'd4,   8'h00);
      vecs[6]  = mk("after_oor_0",  1'b0, 8'd0,   8'h00, 8'd0,   8'h11);
      vecs[7]  = mk("after_oor_1",  1'b0, 8'd0,   8'h00, 8'd1,   8'h22);
      vecs[8]  = mk("after_oor_2",  1'b0, 8'd0,   8'h00, 8'd2,   8'h33);
      vecs[9]  = mk("after_oor_3",  1'b0, 8'd0,   8'h00, 8'd3,   8'h44);
      vecs[10] = mk("oor_wr_rd255", 1'b1, 8'd255, 8'hFF, 8'd255, 8'h00);
      vecs[11] = mk("overwrite2",   1'b1, 8'd2,   8'h80, 8'd2,   8'h80);

      for (int v = 0; v < 12; v++) begin
         @(negedge clock);
         write_enable  = vecs[v].we;
         write_address = vecs[v].waddr;
         write_data    = vecs[v].wdata;
         read_address  = vecs[v].raddr;
         @(posedge clock);
         #1;
         check(vecs[v].name, read_data, vecs[v].exp);
      end
      model[0] = 8'h11; model[1] = 8'h22; model[2] = 8'h80; model[3] = 8'h44;
      @(negedge clock);
      write_enable = 1'b0;
      sweep("table_final");

      // Rolling write i -> address i%4, full sweep after each edge.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         write_enable  = 1'b1;
         write_address = 8'(i % CELL_COUNT);
         write_data    = 8'(i);
         @(posedge clock);
         #1;
         write_enable = 1'b0;
         model[i % CELL_COUNT] = 8'(i);
         sweep("rolling");
      end

      // Reset asserted between edges clears everything immediately.
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      for (int a = 0; a < CELL_COUNT; a++) model[a] = 8'h00;
      sweep("async_reset");
      // Write attempted across an edge while reset is held is discarded.
      write_enable  = 1'b1;
      write_address = 8'd0;
      write_data    = 8'h99;
      @(posedge clock);
      #1;
      sweep("write_in_reset");
      @(negedge clock);
      reset         = 1'b0;
      write_address = 8'd2;
      write_data    = 8'h7F;
      @(posedge clock);
      #1;
      write_enable = 1'b0;
      model[2] = 8'h7F;
      sweep("post_reset_write");

      // Same-address read/write: old value before the edge, new after.
      @(negedge clock);
      write_enable  = 1'b1;
      write_address = 8'd3;
      write_data    = 8'h11;
      @(posedge clock);
      #1;
      write_enable = 1'b0;
      @(negedge clock);
      write_enable  = 1'b1;
      write_address = 8'd3;
      write_data    = 8'h3C;
      read_address  = 8'd3;
      #1;
`ifdef MEMORY_WRITE_BYPASS_EN
      check("same_addr_before", read_data, 8'h3C);
`else
      check("same_addr_before", read_data, 8'h11);
`endif
      @(posedge clock);
      #1;
      check("same_addr_after", read_data, 8'h3C);
      write_enable = 1'b0;
      #1;
      check("same_addr_stored", read_data, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The module SHALL have parameter CELL_COUNT, default 4, giving the number of 8-bit cells; legal range 1..256.
REQ-002 The module SHALL have port clock, input, 1 bit, the single clock; rising edge active.
REQ-003 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The module SHALL have port read_address, input, 8 bits, the cell index for reads.
REQ-005 The module SHALL have port write_address, input, 8 bits, the cell index for writes.
REQ-006 The module SHALL have port write_data, input, 8 bits, the data to store.
REQ-007 The module SHALL have port write_enable, input, 1 bit, the write strobe, sampled at rising clock.
REQ-008 The module SHALL have port read_data, output, 8 bits, the contents of the addressed cell.

Function
REQ-009 Storage SHALL be CELL_COUNT registers, each 8 bits, indexed 0..CELL_COUNT-1.
REQ-010 Write: on rising clock with write_enable=1, reset=0 and write_address<CELL_COUNT, cell[write_address] SHALL take write_data; the new value is visible on read_data after that edge.
REQ-011 Write with write_enable=0 SHALL leave all cells unchanged.
REQ-012 Write with write_address>=CELL_COUNT SHALL be ignored (no cell modified, no wrap-around).
REQ-013 Read SHALL be combinational, with zero clock latency: read_data = cell[read_address] whenever read_address<CELL_COUNT, settling within the same cycle as any address change.
REQ-014 read_address>=CELL_COUNT SHALL yield read_data=8'h00.
REQ-015 Read and write to the same address in one cycle, without bypass (REQ-020), SHALL return the old value before the edge and the new value after it.
REQ-016 Only one cell SHALL change per clock edge; all other cells hold.
REQ-017 write_data SHALL be stored unmodified; there is no arithmetic or width conversion.

Reset
REQ-018 Asserting reset SHALL immediately clear every cell to 8'h00, independent of clock; read_data for any in-range address becomes 8'h00.
REQ-019 While reset=1, writes SHALL be blocked; a write edge coincident with reset is discarded; after deassertion the first rising clock with write_enable=1 writes normally.

Configuration
REQ-020 Macro MEMORY_WRITE_BYPASS_EN: when defined, if write_enable=1, reset=0 and read_address==write_address<CELL_COUNT, read_data SHALL equal write_data combinationally (write-through); when undefined, read_data SHALL always reflect stored contents per REQ-013/015.

Verification
REQ-021 Apply reset pulse; read addresses 0..3 -> read_data=00 for each.
REQ-022 CELL_COUNT=4, write i to address i%4 for i=0..999 at successive edges; after each edge, sweep reads 0..3 -> the last written cell shows i%256, the others show their previous values (e.g. after i=5: cells 04,05,02,03).
REQ-023 write_enable=0, write_data=AA to address 1 -> cell 1 unchanged.
REQ-024 Write 55 to address 4 (CELL_COUNT=4) -> cells 0..3 unchanged; read address 4 -> 00.
REQ-025 Cells filled nonzero, assert reset mid-cycle between edges -> all reads 00 immediately; deassert, write 7F to address 2 -> read 2 = 7F.
REQ-026 Same-address read/write, write_data=3C over old value 11 -> before edge 11 without MEMORY_WRITE_BYPASS_EN, 3C with it; after edge 3C in both builds.
